// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the bit_serializer block.
package bit_serializer_pkg;

    // PAR keeps its encoding even when the parity option is compiled out.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } ser_state_e;

    function automatic int cnt_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: MSB-first bit stream with per-bit enable and idle gap.
// Optional even-parity trailer bit enabled by `define BIT_SERIALIZER_PARITY_EN.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              s_out,
    output logic              s_out_en,
    output logic              busy
);

    localparam int BIT_W      = cnt_w(DATA_W);
    localparam int GAP_W      = cnt_w(GAP_CYCLES + 1);
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

    ser_state_e        state_r;
    ser_state_e        state_s;
    logic [DATA_W-1:0] shreg_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              accept_s;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic              par_r;
`endif

    assign in_ready = (state_r == IDLE) && !rst;
    assign accept_s = in_valid && in_ready;
    assign busy     = (state_r != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == BIT_LAST) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_s = PAR;
`else
                    if (GAP_CYCLES > 0) begin
                        state_s = GAP;
                    end else begin
                        state_s = IDLE;
                    end
`endif
                end else begin
                    state_s = SHIFT;
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PAR: begin
                if (GAP_CYCLES > 0) begin
                    state_s = GAP;
                end else begin
                    state_s = IDLE;
                end
            end
`endif
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Shift register and the bit/gap counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r   <= '0;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shreg_r   <= in_data;
                        bit_cnt_r <= '0;
                        gap_cnt_r <= '0;
                    end
                end
                SHIFT: begin
                    shreg_r   <= {shreg_r[DATA_W-2:0], 1'b0};
                    gap_cnt_r <= '0;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_r <= '0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r <= '0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    gap_cnt_r <= '0;
                end
            endcase
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    // Even parity of the word, captured together with the word itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else if (accept_s) begin
            par_r <= ^in_data;
        end else begin
            par_r <= par_r;
        end
    end
`endif

    // Serial outputs decoded from registered state only.
    always_comb begin
        s_out    = 1'b0;
        s_out_en = 1'b0;
        case (state_r)
            SHIFT: begin
                s_out    = shreg_r[DATA_W-1];
                s_out_en = 1'b1;
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PAR: begin
                s_out    = par_r;
                s_out_en = 1'b1;
            end
`endif
            default: begin
                s_out    = 1'b0;
                s_out_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: two instances (gap 2 and gap 0) against a frame-position model.
module tb_bit_serializer;

    localparam int DATA_W = 8;
    localparam int GAP_A  = 2;
    localparam int GAP_B  = 0;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              rdy_a, so_a, en_a, busy_a;
    logic              rdy_b, so_b, en_b, busy_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    bit                m_act [2];
    logic [DATA_W-1:0] m_word [2];
    int                m_pos [2];
    int                acc_a [$];
    int                acc_b [$];

    logic [DATA_W-1:0] cap_a, cap_b;
    int                na0, nb0;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(DATA_W), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_a), .s_out(so_a), .s_out_en(en_a), .busy(busy_a)
    );

    bit_serializer #(.DATA_W(DATA_W), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_b), .s_out(so_b), .s_out_en(en_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int frame_len(input int i);
        return DATA_W + P + ((i == 0) ? GAP_A : GAP_B);
    endfunction

    function automatic logic exp_en(input int i);
        return m_act[i] && (m_pos[i] < DATA_W + P);
    endfunction

    function automatic logic exp_bit(input int i);
        if (!m_act[i]) return 1'b0;
        if (m_pos[i] < DATA_W) return m_word[i][DATA_W-1-m_pos[i]];
        if (P == 1 && m_pos[i] == DATA_W) return ^m_word[i];
        return 1'b0;
    endfunction

    // Model: each word is a frame of len positions; idle when no frame is in flight.
    always @(posedge clk) begin
        cyc++;
        if (rst) chk_on = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 1'b0;
            end else if (m_act[i]) begin
                m_pos[i]++;
                if (m_pos[i] == frame_len(i)) m_act[i] = 1'b0;
            end else if (in_valid) begin
                m_act[i]  = 1'b1;
                m_word[i] = in_data;
                m_pos[i]  = 0;
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("s_out_a", 32'(so_a), 32'(exp_bit(0)));
            check("s_out_en_a", 32'(en_a), 32'(exp_en(0)));
            check("busy_a", 32'(busy_a), 32'(m_act[0]));
            check("in_ready_a", 32'(rdy_a), 32'(!m_act[0] && !rst));
            check("s_out_b", 32'(so_b), 32'(exp_bit(1)));
            check("s_out_en_b", 32'(en_b), 32'(exp_en(1)));
            check("busy_b", 32'(busy_b), 32'(m_act[1]));
            check("in_ready_b", 32'(rdy_b), 32'(!m_act[1] && !rst));
            if (in_valid && rdy_a) acc_a.push_back(cyc);
            if (in_valid && rdy_b) acc_b.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && !(rdy_a && rdy_b); k++) step();
        check("idle_reached", 32'(rdy_a && rdy_b), 32'd1);
    endtask

    task automatic wait_acc_a(input int n);
        for (int k = 0; k < 60 && acc_a.size() < n; k++) @(posedge clk);
        check("accept_seen_a", 32'(acc_a.size()), 32'(n));
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready_a", 32'(rdy_a), 32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_en_a", 32'(en_a), 32'd0);

        // Single word 0xA5, with in_data scrambled while it shifts.
        step();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        cap_a = '0;
        cap_b = '0;
        repeat (DATA_W) begin
            @(negedge clk);
            cap_a = {cap_a[DATA_W-2:0], so_a};
            cap_b = {cap_b[DATA_W-2:0], so_b};
            @(posedge clk);
            #1 in_data = 8'($urandom);
        end
        check("word_a5_a", 32'(cap_a), 32'h0000_00A5);
        check("word_a5_b", 32'(cap_b), 32'h0000_00A5);
`ifdef BIT_SERIALIZER_PARITY_EN
        @(negedge clk);
        check("parity_a5", 32'(so_a), 32'd0);
        check("parity_a5_en", 32'(en_a), 32'd1);
`endif
        wait_idle();

`ifdef BIT_SERIALIZER_PARITY_EN
        // Odd word: parity bit 1 in cycle t+9.
        step();
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        in_valid = 1'b0;
        repeat (DATA_W + 1) @(negedge clk);
        check("parity_01", 32'(so_a), 32'd1);
        check("parity_01_en", 32'(en_a), 32'd1);
        wait_idle();
`endif

        // Reset held 3 cycles in the middle of a 0xFF word.
        step();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_en_a", 32'(en_a), 32'd0);
        check("midrst_busy_a", 32'(busy_a), 32'd0);
        check("midrst_ready_a", 32'(rdy_a), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready_a", 32'(rdy_a), 32'd1);
        check("midrst_release_en_a", 32'(en_a), 32'd0);

        // Back-to-back with in_valid held high.
        step();
        na0 = acc_a.size();
        nb0 = acc_b.size();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        wait_acc_a(na0 + 1);
        in_data = 8'hC3;
        wait_acc_a(na0 + 2);
        in_data = 8'($urandom);
        repeat (30) begin
            step();
            in_data = 8'($urandom);
        end
        in_valid = 1'b0;
        wait_idle();
        for (int i = na0 + 1; i < acc_a.size(); i++)
            check("period_a", 32'(acc_a[i] - acc_a[i-1]), 32'(DATA_W + P + GAP_A + 1));
        for (int i = nb0 + 1; i < acc_b.size(); i++)
            check("period_b", 32'(acc_b[i] - acc_b[i-1]), 32'(DATA_W + P + GAP_B + 1));

        // Randomized traffic with occasional resets.
        repeat (1500) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 40) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
